// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Definitions shared by the CNN accelerator sequencers (convolution, pooling).
//   CH_PER_WORD : channels packed into one feature-map word
//   LANE_W      : width of the lane index inside a packed word
//   seq_state_t : layer sequencer state encoding
//   ceil_div    : integer ceiling division for parameter arithmetic
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CH_PER_WORD = 4;
    localparam int LANE_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/delay_line.sv
// ---------------------------------------------------------------------------
// delay_line
// Fixed-latency register pipeline: q is d delayed by DEPTH clock cycles.
// Synchronous active-high reset empties every stage.
//   clk : clock
//   rst : synchronous reset, active-high
//   d   : WIDTH-bit input word
//   q   : WIDTH-bit output word, DEPTH cycles after d
// DEPTH must be at least 1.
// ---------------------------------------------------------------------------
module delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] data_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) data_reg <= '0;
                    else     data_reg <= d;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) data_reg <= '0;
                    else     data_reg <= g_stage[gi-1].data_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
// Counts MAC steps for one convolution layer, marks each finished output
// neuron and produces the packed output-RAM write (address, lane, strobe)
// aligned with the MAC pipeline latency.
//   clk        : clock
//   rst        : synchronous reset, active-high
//   start      : one-cycle pulse, begins a layer (honoured in IDLE only)
//   step_valid : datapath consumed one MAC step this cycle
//   step_ready : high in RUN, steps are accepted
//   acc_clear  : first step of a neuron is being accepted
//   neuron_rdy : registered pulse after the last step of a neuron
//   wr_en      : output RAM write strobe (neuron_rdy + PIPE_DLY cycles)
//   wr_addr    : (oc/4)*OUT_R*OUT_C + pix, valid with wr_en
//   wr_lane    : oc%4, valid with wr_en
//   plane_done : pulses with neuron_rdy of the last pixel of a plane
//   layer_done : one-cycle pulse one cycle after the final write
//   busy       : sequencer is not IDLE
// ---------------------------------------------------------------------------
module conv_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int IN_CH    = 1,
    parameter int KSIZE    = 5,
    parameter int OUT_R    = 28,
    parameter int OUT_C    = 28,
    parameter int OUT_CH   = 6,
    parameter int PIPE_DLY = 2,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_valid,
    output logic              step_ready,
    output logic              acc_clear,
    output logic              neuron_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANE_W-1:0] wr_lane,
    output logic              plane_done,
    output logic              layer_done,
    output logic              busy
);

    localparam int GROUPS = ceil_div(IN_CH, CH_PER_WORD);
    localparam int STEPS  = GROUPS * KSIZE * KSIZE;
    localparam int PIX    = OUT_R * OUT_C;
    localparam int SW     = (STEPS > 1)  ? $clog2(STEPS)  : 1;
    localparam int PW     = (PIX > 1)    ? $clog2(PIX)    : 1;
    localparam int OW     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int DW     = $clog2(PIPE_DLY + 1);
    localparam int PKT_W  = 1 + ADDR_W + LANE_W;

    // Elaboration-time parameter sanity.
    generate
        if (PIPE_DLY < 1) begin : g_bad_dly
            $error("conv_layer_sequencer: PIPE_DLY must be >= 1");
        end
        if (longint'(ceil_div(OUT_CH, CH_PER_WORD)) * longint'(PIX) > (64'd1 << ADDR_W)) begin : g_bad_addr
            $error("conv_layer_sequencer: output map does not fit in ADDR_W");
        end
    endgenerate

    seq_state_t        state_reg, state_next;
    logic [SW-1:0]     step_cnt_reg, step_cnt_next;
    logic [PW-1:0]     pix_reg, pix_next;
    logic [OW-1:0]     oc_reg, oc_next;
    logic [DW-1:0]     drain_reg, drain_next;
    logic              neuron_rdy_reg, neuron_rdy_next;
    logic              plane_done_reg, plane_done_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LANE_W-1:0] lane_reg, lane_next;

    logic              accept;
    logic              last_step;
    logic              last_pix;
    logic              last_oc;
    logic [ADDR_W-1:0] neuron_addr;
    logic [LANE_W-1:0] neuron_lane;
    logic [PKT_W-1:0]  pkt_in;
    logic [PKT_W-1:0]  pkt_out;

    assign accept    = (state_reg == RUN) && step_valid;
    assign last_step = (step_cnt_reg == SW'(STEPS - 1));
    assign last_pix  = (pix_reg == PW'(PIX - 1));
    assign last_oc   = (oc_reg == OW'(OUT_CH - 1));

    // Address of the neuron currently being accumulated, taken from pix/oc
    // before they advance. Computed at 32 bits and truncated to ADDR_W.
    assign neuron_addr = ADDR_W'((32'(oc_reg) / 32'(CH_PER_WORD)) * 32'(PIX) + 32'(pix_reg));
    assign neuron_lane = LANE_W'(32'(oc_reg) % 32'(CH_PER_WORD));

    always_comb begin
        state_next      = state_reg;
        step_cnt_next   = step_cnt_reg;
        pix_next        = pix_reg;
        oc_next         = oc_reg;
        drain_next      = drain_reg;
        neuron_rdy_next = 1'b0;
        plane_done_next = 1'b0;
        addr_next       = addr_reg;
        lane_next       = lane_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    step_cnt_next = '0;
                    pix_next      = '0;
                    oc_next       = '0;
                    drain_next    = '0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                if (step_valid) begin
                    if (last_step) begin
                        step_cnt_next   = '0;
                        neuron_rdy_next = 1'b1;
                        addr_next       = neuron_addr;
                        lane_next       = neuron_lane;
                        if (last_pix) begin
                            pix_next        = '0;
                            plane_done_next = 1'b1;
                            if (last_oc) begin
                                oc_next    = '0;
                                drain_next = '0;
                                state_next = DRAIN;
                            end else begin
                                oc_next = oc_reg + OW'(1);
                            end
                        end else begin
                            pix_next = pix_reg + PW'(1);
                        end
                    end else begin
                        step_cnt_next = step_cnt_reg + SW'(1);
                    end
                end
            end
            DRAIN: begin
                // Holds until the last neuron's write has left the delay line,
                // so layer_done lands one cycle after the final wr_en.
                if (drain_reg == DW'(PIPE_DLY)) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            step_cnt_reg   <= '0;
            pix_reg        <= '0;
            oc_reg         <= '0;
            drain_reg      <= '0;
            neuron_rdy_reg <= 1'b0;
            plane_done_reg <= 1'b0;
            addr_reg       <= '0;
            lane_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            step_cnt_reg   <= step_cnt_next;
            pix_reg        <= pix_next;
            oc_reg         <= oc_next;
            drain_reg      <= drain_next;
            neuron_rdy_reg <= neuron_rdy_next;
            plane_done_reg <= plane_done_next;
            addr_reg       <= addr_next;
            lane_reg       <= lane_next;
        end
    end

    // The write packet enters the delay line on the neuron_rdy cycle, so it
    // emerges exactly PIPE_DLY cycles later; reset flushes anything in flight.
    assign pkt_in = {neuron_rdy_reg, addr_reg, lane_reg};

    delay_line #(
        .DEPTH (PIPE_DLY),
        .WIDTH (PKT_W)
    ) u_wr_align (
        .clk (clk),
        .rst (rst),
        .d   (pkt_in),
        .q   (pkt_out)
    );

    assign wr_en      = pkt_out[PKT_W-1];
    assign wr_addr    = pkt_out[LANE_W +: ADDR_W];
    assign wr_lane    = pkt_out[LANE_W-1:0];

    assign step_ready = (state_reg == RUN);
    assign acc_clear  = accept && (step_cnt_reg == '0);
    assign neuron_rdy = neuron_rdy_reg;
    assign plane_done = plane_done_reg;
    assign layer_done = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sequencer
// Bench for conv_layer_sequencer using a reduced layer geometry so a whole
// layer fits in a short run: IN_CH=5 (two channel groups), KSIZE=2,
// 3x5 output plane, 6 output channels, PIPE_DLY=3. STEPS=8, PIX=15.
// Expected writes come from the neuron ordering: neuron i has oc=i/PIX,
// pix=i%PIX, address (oc/4)*PIX+pix and lane oc%4.
// ---------------------------------------------------------------------------
module tb_conv_layer_sequencer;

    localparam int IN_CH    = 5;
    localparam int KSIZE    = 2;
    localparam int OUT_R    = 3;
    localparam int OUT_C    = 5;
    localparam int OUT_CH   = 6;
    localparam int PIPE_DLY = 3;
    localparam int ADDR_W   = 8;

    localparam int STEPS   = ((IN_CH + 3) / 4) * KSIZE * KSIZE;
    localparam int PIX     = OUT_R * OUT_C;
    localparam int NEURONS = OUT_CH * PIX;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              step_valid = 1'b0;
    logic              step_ready;
    logic              acc_clear;
    logic              neuron_rdy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_lane;
    logic              plane_done;
    logic              layer_done;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int step_idx = 0;

    int nr_q[$];
    int wr_cyc_q[$];
    int wr_addr_q[$];
    int wr_lane_q[$];
    int pd_q[$];
    int ld_q[$];

    conv_layer_sequencer #(
        .IN_CH    (IN_CH),
        .KSIZE    (KSIZE),
        .OUT_R    (OUT_R),
        .OUT_C    (OUT_C),
        .OUT_CH   (OUT_CH),
        .PIPE_DLY (PIPE_DLY),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .acc_clear  (acc_clear),
        .neuron_rdy (neuron_rdy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_lane    (wr_lane),
        .plane_done (plane_done),
        .layer_done (layer_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled 2 time units after the clock edge.
    always @(posedge clk) begin
        #2;
        if (neuron_rdy) nr_q.push_back(cyc);
        if (wr_en) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(wr_addr));
            wr_lane_q.push_back(int'(wr_lane));
        end
        if (plane_done) pd_q.push_back(cyc);
        if (layer_done) ld_q.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int model_addr(input int i);
        int oc;
        int pix;
        oc  = i / PIX;
        pix = i % PIX;
        return ((oc / 4) * PIX + pix) % (1 << ADDR_W);
    endfunction

    function automatic int model_lane(input int i);
        return (i / PIX) % 4;
    endfunction

    function automatic int write_seq_errors();
        int e;
        e = (wr_addr_q.size() != NEURONS) ? 1 : 0;
        for (int i = 0; i < wr_addr_q.size() && i < NEURONS; i++) begin
            if (wr_addr_q[i] != model_addr(i) || wr_lane_q[i] != model_lane(i)) e++;
        end
        return e;
    endfunction

    // wr_en must trail each neuron_rdy by PIPE_DLY; plane_done must coincide
    // with the neuron_rdy of every PIX-th neuron.
    function automatic int timing_errors();
        int e;
        e = 0;
        if (nr_q.size() != NEURONS || wr_cyc_q.size() != NEURONS) e++;
        for (int i = 0; i < nr_q.size() && i < wr_cyc_q.size(); i++) begin
            if (wr_cyc_q[i] - nr_q[i] != PIPE_DLY) e++;
        end
        if (pd_q.size() != OUT_CH) e++;
        for (int k = 0; k < pd_q.size(); k++) begin
            if ((k + 1) * PIX - 1 >= nr_q.size()) e++;
            else if (pd_q[k] != nr_q[(k + 1) * PIX - 1]) e++;
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // ------------------------------------------------------------------
    task automatic clear_queues();
        nr_q.delete();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_lane_q.delete();
        pd_q.delete();
        ld_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives n accepted steps; gap_pct is the chance of an idle cycle before
    // each step; poke scatters start pulses that must be ignored. acc_err
    // counts cycles where acc_clear/step_ready disagree with the model.
    task automatic drive_steps(input int n, input int gap_pct, input bit poke,
                               output int acc_err);
        acc_err = 0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < 32'(gap_pct)) begin
                step_valid = 1'b0;
                start = poke && ($urandom_range(3) == 0);
                @(negedge clk);
                start = 1'b0;
            end
            step_valid = 1'b1;
            start = poke && ($urandom_range(7) == 0);
            #1;
            if (acc_clear !== ((step_idx % STEPS) == 0) || step_ready !== 1'b1) acc_err++;
            @(negedge clk);
            start = 1'b0;
            step_valid = 1'b0;
            step_idx++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [17:0] outs;
        rst = 1'b1;
        step_valid = 1'b1;
        repeat (3) @(negedge clk);
        outs = {step_ready, acc_clear, neuron_rdy, wr_en, wr_addr, wr_lane,
                plane_done, layer_done, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        outs = {step_ready, acc_clear, neuron_rdy, wr_en, wr_addr, wr_lane,
                plane_done, layer_done, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL idle_ignores_steps: got %h expected 0", outs);
        end
        step_valid = 1'b0;
        n_tests++;
        if (nr_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_neuron: got %0d expected 0", nr_q.size());
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_first_neuron();
        int acc_err;
        int nr_err;
        int early_wr;
        clear_queues();
        step_idx = 0;
        pulse_start();
        n_tests++;
        if ({step_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL run_entry: got %b expected 11", {step_ready, busy});
        end
        acc_err = 0;
        nr_err = 0;
        for (int k = 0; k < STEPS; k++) begin
            step_valid = 1'b1;
            #1;
            if (acc_clear !== (k == 0)) acc_err++;
            @(negedge clk);
            if (k < STEPS - 1 && neuron_rdy !== 1'b0) nr_err++;
            step_idx++;
        end
        step_valid = 1'b0;
        n_tests++;
        if (acc_err != 0) begin
            n_fail++;
            $display("FAIL acc_clear_first: got %0d bad cycles expected 0", acc_err);
        end
        n_tests++;
        if (neuron_rdy !== 1'b1 || nr_err != 0) begin
            n_fail++;
            $display("FAIL neuron_rdy_latency: got %b (early %0d) expected 1", neuron_rdy, nr_err);
        end
        early_wr = 0;
        for (int d = 1; d < PIPE_DLY; d++) begin
            @(negedge clk);
            if (wr_en !== 1'b0) early_wr++;
        end
        @(negedge clk);
        n_tests++;
        if (wr_en !== 1'b1 || early_wr != 0) begin
            n_fail++;
            $display("FAIL wr_en_delay: got %b (early %0d) expected 1", wr_en, early_wr);
        end
        n_tests++;
        if (wr_addr !== ADDR_W'(model_addr(0)) || wr_lane !== 2'(model_lane(0))) begin
            n_fail++;
            $display("FAIL first_write: got addr %0d lane %0d expected addr %0d lane %0d",
                     wr_addr, wr_lane, model_addr(0), model_lane(0));
        end
        $display("[TB] test_first_neuron done");
    endtask

    // Continues the layer begun by test_first_neuron with back-to-back steps
    // and scattered start pulses, then pulses start on the layer_done cycle.
    task automatic test_full_layer();
        int acc_err;
        int e;
        int waited;
        int n_last;
        drive_steps(NEURONS * STEPS - step_idx, 0, 1'b1, acc_err);
        n_tests++;
        if (acc_err != 0) begin
            n_fail++;
            $display("FAIL acc_clear_cont: got %0d bad cycles expected 0", acc_err);
        end
        waited = 0;
        while (layer_done !== 1'b1 && waited < PIPE_DLY + 10) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (layer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL layer_done_seen: got 0 expected 1");
        end
        pulse_start();
        n_tests++;
        if ({busy, step_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_at_done: got busy/ready %b expected 00", {busy, step_ready});
        end
        step_valid = 1'b1;
        repeat (5) @(negedge clk);
        step_valid = 1'b0;
        @(negedge clk);
        e = write_seq_errors();
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL wr_seq_cont: got %0d errors (%0d writes) expected 0", e, wr_addr_q.size());
        end
        n_last = wr_addr_q.size();
        n_tests++;
        if (n_last == 0 || wr_addr_q[n_last-1] != model_addr(NEURONS - 1) ||
            wr_lane_q[n_last-1] != model_lane(NEURONS - 1)) begin
            n_fail++;
            $display("FAIL last_write: got %0d writes, expected last addr %0d lane %0d",
                     n_last, model_addr(NEURONS - 1), model_lane(NEURONS - 1));
        end
        e = timing_errors();
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL pipe_timing_cont: got %0d errors expected 0", e);
        end
        n_tests++;
        if (ld_q.size() != 1 || n_last == 0 || ld_q[0] != wr_cyc_q[n_last-1] + 1) begin
            n_fail++;
            $display("FAIL layer_done_timing: got %0d pulses expected 1 at last write + 1", ld_q.size());
        end
        n_tests++;
        if (busy !== 1'b0 || nr_q.size() != NEURONS) begin
            n_fail++;
            $display("FAIL idle_after_layer: got busy %b neurons %0d expected 0 and %0d",
                     busy, nr_q.size(), NEURONS);
        end
        $display("[TB] test_full_layer done");
    endtask

    task automatic test_random_gaps();
        int acc_err;
        int e;
        int waited;
        clear_queues();
        step_idx = 0;
        pulse_start();
        drive_steps(NEURONS * STEPS, 50, 1'b1, acc_err);
        n_tests++;
        if (acc_err != 0) begin
            n_fail++;
            $display("FAIL acc_clear_gaps: got %0d bad cycles expected 0", acc_err);
        end
        waited = 0;
        while (busy === 1'b1 && waited < PIPE_DLY + 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        e = write_seq_errors();
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL wr_seq_gaps: got %0d errors (%0d writes) expected 0", e, wr_addr_q.size());
        end
        e = timing_errors();
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL pipe_timing_gaps: got %0d errors expected 0", e);
        end
        n_tests++;
        if (ld_q.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL layer_end_gaps: got %0d layer_done busy %b expected 1 and 0", ld_q.size(), busy);
        end
        $display("[TB] test_random_gaps done");
    endtask

    task automatic test_rst_mid_layer();
        int acc_err;
        logic [17:0] outs;
        clear_queues();
        step_idx = 0;
        pulse_start();
        drive_steps(STEPS, 0, 1'b0, acc_err);
        n_tests++;
        if (neuron_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_neuron: got %b expected 1", neuron_rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs = {step_ready, acc_clear, neuron_rdy, wr_en, wr_addr, wr_lane,
                plane_done, layer_done, busy};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        repeat (PIPE_DLY + 3) @(negedge clk);
        n_tests++;
        if (wr_cyc_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_flush: got %0d writes expected 0", wr_cyc_q.size());
        end
        clear_queues();
        step_idx = 0;
        pulse_start();
        drive_steps(STEPS, 0, 1'b0, acc_err);
        repeat (PIPE_DLY + 1) @(negedge clk);
        n_tests++;
        if (wr_addr_q.size() != 1 || acc_err != 0 ||
            wr_addr_q[0] != model_addr(0) || wr_lane_q[0] != model_lane(0)) begin
            n_fail++;
            $display("FAIL restart_first_write: got %0d writes (acc err %0d) expected one to addr %0d lane %0d",
                     wr_addr_q.size(), acc_err, model_addr(0), model_lane(0));
        end
        $display("[TB] test_rst_mid_layer done");
    endtask

    initial begin
        test_reset();
        test_first_neuron();
        test_full_layer();
        test_random_gaps();
        test_rst_mid_layer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
